// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | digit_scan_ctrl : N-digit multiplexed display scanner with PWM and guard    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module digit_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4,
  parameter int GUARD       = 2,
  parameter bit ACTIVE_LOW  = 1'b1,
  localparam int SEL_W      = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [SEL_W-1:0]      digit_sel,
  output logic                  slot_start
);

  localparam int C_CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [31:0] C_STEP  = REFRESH_DIV / (1 << BRIGHT_W);
  localparam logic [31:0] C_GUARD = GUARD;
  localparam logic [C_CNT_W-1:0] C_PRE_LAST = C_CNT_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0]   C_SEL_LAST = SEL_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2) begin : g_chk_digits
    $error("digit_scan_ctrl: NUM_DIGITS must be >= 2");
  end
  if ((REFRESH_DIV % (1 << BRIGHT_W)) != 0) begin : g_chk_div
    $error("digit_scan_ctrl: REFRESH_DIV must be divisible by 2**BRIGHT_W");
  end
  if ((GUARD < 1) || (GUARD >= int'(C_STEP))) begin : g_chk_guard
    $error("digit_scan_ctrl: GUARD must satisfy 1 <= GUARD < STEP");
  end

  logic [C_CNT_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [SEL_W-1:0]      digit_sel_q, digit_sel_d;
  logic [BRIGHT_W-1:0]   bri_sh_q, bri_sh_d;
  logic [NUM_DIGITS-1:0] mask_sh_q, mask_sh_d;

  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    digit_sel_d = digit_sel_q;
    bri_sh_d    = bri_sh_q;
    mask_sh_d   = mask_sh_q;
    if (enable) begin
      // Shadows capture during the always-dark first cycle of a slot.
      if (pre_cnt_q == '0) begin
        bri_sh_d  = brightness;
        mask_sh_d = blank_mask;
      end
      if (pre_cnt_q == C_PRE_LAST) begin
        pre_cnt_d   = '0;
        digit_sel_d = (digit_sel_q == C_SEL_LAST) ? '0 : digit_sel_q + SEL_W'(1);
      end else begin
        pre_cnt_d = pre_cnt_q + C_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q   <= '0;
      digit_sel_q <= '0;
      bri_sh_q    <= '1;
      mask_sh_q   <= '0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      digit_sel_q <= digit_sel_d;
      bri_sh_q    <= bri_sh_d;
      mask_sh_q   <= mask_sh_d;
    end
  end

  logic [31:0]           on_cycles;
  logic                  in_window;
  logic [NUM_DIGITS-1:0] lit_vec;

  always_comb begin
    on_cycles = (32'(bri_sh_q) + 32'd1) * C_STEP;
    in_window = (32'(pre_cnt_q) >= C_GUARD) && (32'(pre_cnt_q) < on_cycles);
    lit_vec   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lit_vec[i] = enable && in_window && !mask_sh_q[i] && (digit_sel_q == SEL_W'(i));
    end
    digit_en   = ACTIVE_LOW ? ~lit_vec : lit_vec;
    slot_start = enable && (pre_cnt_q == '0);
  end

  assign digit_sel = digit_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_digit_scan_ctrl : directed bench for digit_scan_ctrl (4 digits, DIV 16) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_digit_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] brightness = 2'd3;
  logic [3:0] blank_mask = 4'd0;
  logic [3:0] digit_en, digit_en_hi;
  logic [1:0] digit_sel, digit_sel_hi;
  logic       slot_start, slot_start_hi;

  int n_cmp = 0;
  int n_err = 0;
  int lit_cnt, lit_hi_cnt, ss_cnt;

  // Reference state for the scanner
  int         m_pre, m_sel, m_bri;
  logic [3:0] m_mask;

  always #5 clk = ~clk;

  digit_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(16), .BRIGHT_W(2), .GUARD(1), .ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .brightness(brightness),
    .blank_mask(blank_mask), .digit_en(digit_en), .digit_sel(digit_sel),
    .slot_start(slot_start)
  );

  digit_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(16), .BRIGHT_W(2), .GUARD(1), .ACTIVE_LOW(1'b0)
  ) u_dut_hi (
    .clk(clk), .reset(reset), .enable(enable), .brightness(brightness),
    .blank_mask(blank_mask), .digit_en(digit_en_hi), .digit_sel(digit_sel_hi),
    .slot_start(slot_start_hi)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: check outputs against the reference, then advance both.
  task automatic cycle();
    logic       exp_lit;
    logic [3:0] exp_en;
    logic [3:0] one;
    #1;
    one     = 4'b0001;
    exp_lit = enable && !m_mask[m_sel] && (m_pre >= 1) && (m_pre < (m_bri + 1) * 4);
    exp_en  = exp_lit ? ~(one << m_sel) : 4'hF;
    check_eq("digit_en", {28'd0, digit_en}, {28'd0, exp_en});
    check_eq("digit_en_hi", {28'd0, digit_en_hi}, {28'd0, ~exp_en});
    check_eq("digit_sel", {30'd0, digit_sel}, m_sel);
    check_eq("slot_start", {31'd0, slot_start}, {31'd0, enable && (m_pre == 0)});
    if (digit_en != 4'hF) lit_cnt++;
    if (digit_en_hi != 4'h0) lit_hi_cnt++;
    if (slot_start) ss_cnt++;
    if (reset) begin
      m_pre = 0; m_sel = 0; m_bri = 3; m_mask = 4'd0;
    end else if (enable) begin
      if (m_pre == 0) begin
        m_bri  = int'(brightness);
        m_mask = blank_mask;
      end
      if (m_pre == 15) begin
        m_pre = 0;
        m_sel = (m_sel == 3) ? 0 : m_sel + 1;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_counts();
    lit_cnt = 0; lit_hi_cnt = 0; ss_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_pre = 0; m_sel = 0; m_bri = 3; m_mask = 4'd0;
    #1;
    check_eq("rst_digit_en", {28'd0, digit_en}, 32'hF);
    check_eq("rst_digit_en_hi", {28'd0, digit_en_hi}, 32'h0);
    check_eq("rst_digit_sel", {30'd0, digit_sel}, 32'd0);
    check_eq("rst_slot_start", {31'd0, slot_start}, 32'd0);
    clear_counts();
    run(2);
    check_eq("disabled_lit", lit_cnt, 0);

    // Full brightness, no mask: 15 lit cycles per slot
    enable = 1'b1; brightness = 2'd3; blank_mask = 4'd0;
    clear_counts();
    run(1);
    check_eq("s1_pre1_en", {28'd0, digit_en}, 32'hE);
    run(63);
    check_eq("s1_lit", lit_cnt, 60);
    check_eq("s1_slot_starts", ss_cnt, 4);
    check_eq("s1_wrap_sel", {30'd0, digit_sel}, 32'd0);

    // Reduced brightness
    brightness = 2'd1;
    clear_counts();
    run(64);
    check_eq("s2_bri1_lit", lit_cnt, 28);
    brightness = 2'd0;
    clear_counts();
    run(64);
    check_eq("s2_bri0_lit", lit_cnt, 12);

    // Blank mask on digit 2
    brightness = 2'd3; blank_mask = 4'b0100;
    clear_counts();
    run(64);
    check_eq("s3_mask_lit", lit_cnt, 45);
    check_eq("s3_slot_starts", ss_cnt, 4);

    // Brightness change mid-slot only affects the next slot
    blank_mask = 4'd0;
    run(6);
    brightness = 2'd0;
    clear_counts();
    run(10);
    check_eq("s4_cur_slot_lit", lit_cnt, 10);
    clear_counts();
    run(16);
    check_eq("s4_next_slot_lit", lit_cnt, 3);

    // Hold at pre_cnt 5, digit 2
    brightness = 2'd3;
    run(5);
    enable = 1'b0;
    clear_counts();
    run(10);
    check_eq("s5_hold_lit", lit_cnt, 0);
    check_eq("s5_hold_starts", ss_cnt, 0);
    enable = 1'b1;
    #1;
    check_eq("s5_resume_en", {28'd0, digit_en}, 32'hB);
    check_eq("s5_resume_sel", {30'd0, digit_sel}, 32'd2);
    run(11);

    // Reset mid-scan at pre_cnt 9, digit 3
    run(9);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    #1;
    check_eq("s6_sel", {30'd0, digit_sel}, 32'd0);
    check_eq("s6_en", {28'd0, digit_en}, 32'hF);
    check_eq("s6_slot_start", {31'd0, slot_start}, 32'd1);

    // Active-high instance over a full-brightness scan
    brightness = 2'd3; blank_mask = 4'd0;
    clear_counts();
    run(64);
    check_eq("s6_hi_lit", lit_hi_cnt, 60);
    check_eq("s6_lo_lit", lit_cnt, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
